// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction-fetch stage.
// Bus widths follow the existing IF/ID and branch bus layout.
package if_prefetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam int INST_W      = 32;
  localparam int IF_TO_ID_WD = 1 + 2 * INST_W;
  localparam int BR_WD       = 33;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [INST_W-1:0] pc_next(
    input logic [INST_W-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction SRAM request/response and IF->ID handshake bundle.
// master is the fetch stage, slave is the SRAM + decode side.
interface if_prefetch_if;
  import if_prefetch_pkg::*;

  logic              inst_sram_en;
  logic [3:0]        inst_sram_wen;
  logic [INST_W-1:0] inst_sram_addr;
  logic [INST_W-1:0] inst_sram_wdata;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [INST_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata,
    output id_valid,
    output id_pc,
    output id_inst,
    input  id_ready
  );

  modport slave (
    input  inst_sram_en,
    input  inst_sram_wen,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata,
    input  id_valid,
    input  id_pc,
    input  id_inst,
    output id_ready
  );

endinterface

// File: rtl/if_prefetch_fetch_fifo.sv
// Synchronous prefetch queue; clear drops every entry at the edge.
// Storage is unreset: only the pointers and count carry state.
module if_prefetch_fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PTR_W'(1);
      if (pop)  rd_q <= rd_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

  overflow_chk: assert property (
    @(posedge clk) disable iff (rst || clear)
    !(push && !pop && cnt_q == FULL)
  );

endmodule

// File: rtl/if_prefetch.sv
// Prefetching IF stage: credit-based sequential fetch into a small queue,
// with branch/exception redirect discarding queued and in-flight words.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter  logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter  int          QUEUE_DEPTH = 4,
  localparam int          PTR_W       = $clog2(QUEUE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [INST_W-1:0] new_pc,
  input  logic              br_e,
  input  logic [INST_W-1:0] br_addr,
  if_prefetch_if.master     bus,
  output logic [PTR_W:0]    q_count
);

  localparam logic [PTR_W+1:0] CAP = (PTR_W+2)'(QUEUE_DEPTH);

  logic [BR_WD-1:0]  br_bus;
  logic              redir;
  logic [INST_W-1:0] target;
  logic [INST_W-1:0] issue_addr;
  logic [PTR_W+1:0]  occ;
  logic              issue;
  logic              push;
  logic              pop;
  logic              id_v;
  logic [PTR_W:0]    cnt;
  fetch_entry_t      head;
  fetch_entry_t      push_ent;

  logic [INST_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q;
  logic [INST_W-1:0] inflight_pc_q;

  assign br_bus = {br_e, br_addr};
  assign redir  = flush | br_bus[BR_WD-1];
  assign target = flush ? new_pc : br_bus[INST_W-1:0];

  // a redirect empties the queue and kills the in-flight word,
  // so the credit check sees zero occupancy that cycle
  assign occ   = {1'b0, cnt} + {{(PTR_W+1){1'b0}}, inflight_q};
  assign issue = !rst && (redir || occ < CAP);

  assign issue_addr = redir ? target : fetch_pc_q;
  assign fetch_pc_d = issue ? pc_next(issue_addr) : issue_addr;

  assign id_v = !rst && (cnt != '0);
  assign push = inflight_q && !redir;
  assign pop  = id_v && bus.id_ready && !redir;

  assign push_ent.pc   = inflight_pc_q;
  assign push_ent.inst = bus.inst_sram_rdata;

  if_prefetch_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redir),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head      (head),
    .count     (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= issue_addr;
    end
  end

  assign bus.inst_sram_en    = issue;
  assign bus.inst_sram_wen   = 4'b0;
  assign bus.inst_sram_addr  = issue_addr;
  assign bus.inst_sram_wdata = '0;
  assign bus.id_valid        = id_v;
  assign bus.id_pc           = head.pc;
  assign bus.id_inst         = head.inst;
  assign q_count             = rst ? '0 : cnt;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: hand-derived vector table plus a queue-level
// reference model driven by directed and random sequences.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst, flush, br_e;
  logic [31:0] new_pc, br_addr;
  logic [2:0]  q_count;

  if_prefetch_if bus();

  if_prefetch #(
    .RESET_PC    (RPC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .new_pc  (new_pc),
    .br_e    (br_e),
    .br_addr (br_addr),
    .bus     (bus),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ?
                           mem_word(bus.inst_sram_addr) : 32'hDEAD_BEEF;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit rst; bit fl; logic [31:0] npc; bit br; logic [31:0] ba; bit rdy;
    bit v; logic [31:0] pc; bit en; logic [31:0] addr; int cnt;
  } vec_t;

  vec_t tbl[19];

  // reference model: a queue of PCs, one optional in-flight fetch
  logic [31:0] m_fetch = RPC;
  bit          m_infl  = 1'b0;
  logic [31:0] m_infl_pc = '0;
  logic [31:0] mq[$];

  task automatic model_step();
    bit          r, rd, rdy, en_e;
    logic [31:0] tgt, addr_e;
    int          sz;
    #1;
    r    = rst;
    rd   = flush | br_e;
    rdy  = bus.id_ready;
    tgt  = flush ? new_pc : br_addr;
    sz   = mq.size();
    en_e = !r && (rd || (sz + int'(m_infl) < DEPTH));
    addr_e = rd ? tgt : m_fetch;
    chk("m_en", bus.inst_sram_en, en_e);
    if (en_e) chk("m_addr", bus.inst_sram_addr, addr_e);
    chk("m_valid", bus.id_valid, !r && sz != 0);
    chk("m_count", q_count, r ? 0 : sz);
    if (!r && sz != 0) begin
      chk("m_pc", bus.id_pc, mq[0]);
      chk("m_inst", bus.id_inst, mem_word(mq[0]));
    end
    @(posedge clk);
    if (r) begin
      m_fetch = RPC;
      mq.delete();
      m_infl = 1'b0;
    end else begin
      if (rd) mq.delete();
      else begin
        if (sz != 0 && rdy) void'(mq.pop_front());
        if (m_infl) mq.push_back(m_infl_pc);
      end
      if (en_e) begin
        m_infl = 1'b1;
        m_infl_pc = addr_e;
        m_fetch = addr_e + 32'd4;
      end else begin
        m_infl = 1'b0;
        m_fetch = rd ? tgt : m_fetch;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; br_e = 0; new_pc = '0; br_addr = '0;
  endtask

  task automatic fill_to3(input string nm);
    bus.id_ready = 1'b0;
    for (int k = 0; k < 20 && q_count != 3; k++) model_step();
    chk(nm, q_count, 3);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0,1, 0,0,            0,0,            0};
    tbl[1]  = '{0,0,0,0,0,1, 0,0,            1,32'hBFC00000, 0};
    tbl[2]  = '{0,0,0,0,0,1, 0,0,            1,32'hBFC00004, 0};
    tbl[3]  = '{0,0,0,0,0,1, 1,32'hBFC00000, 1,32'hBFC00008, 1};
    tbl[4]  = '{0,0,0,0,0,1, 1,32'hBFC00004, 1,32'hBFC0000C, 1};
    tbl[5]  = '{0,0,0,0,0,0, 1,32'hBFC00008, 1,32'hBFC00010, 1};
    tbl[6]  = '{0,0,0,0,0,0, 1,32'hBFC00008, 1,32'hBFC00014, 2};
    tbl[7]  = '{0,0,0,0,0,0, 1,32'hBFC00008, 0,0,            3};
    tbl[8]  = '{0,0,0,0,0,0, 1,32'hBFC00008, 0,0,            4};
    tbl[9]  = '{0,0,0,0,0,1, 1,32'hBFC00008, 0,0,            4};
    tbl[10] = '{0,0,0,0,0,1, 1,32'hBFC0000C, 1,32'hBFC00018, 3};
    tbl[11] = '{0,0,0,1,32'h80000100,1, 1,32'hBFC00010,
                1,32'h80000100, 2};
    tbl[12] = '{0,0,0,0,0,1, 0,0,            1,32'h80000104, 0};
    tbl[13] = '{0,0,0,0,0,1, 1,32'h80000100, 1,32'h80000108, 1};
    tbl[14] = '{0,1,32'hBFC00380,1,32'h1000,1, 1,32'h80000104,
                1,32'hBFC00380, 1};
    tbl[15] = '{0,0,0,0,0,1, 0,0,            1,32'hBFC00384, 0};
    tbl[16] = '{0,0,0,0,0,1, 1,32'hBFC00380, 1,32'hBFC00388, 1};
    tbl[17] = '{1,0,0,0,0,1, 0,0,            0,0,            0};
    tbl[18] = '{0,0,0,0,0,1, 0,0,            1,32'hBFC00000, 0};

    idle_inputs();
    rst = 1; bus.id_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", bus.inst_sram_wen, 0);
    chk("rst_wdata", bus.inst_sram_wdata, 0);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; flush = tbl[i].fl; new_pc = tbl[i].npc;
      br_e = tbl[i].br; br_addr = tbl[i].ba; bus.id_ready = tbl[i].rdy;
      #1;
      chk($sformatf("t%0d_en", i), bus.inst_sram_en, tbl[i].en);
      if (tbl[i].en) chk($sformatf("t%0d_addr", i), bus.inst_sram_addr,
                         tbl[i].addr);
      chk($sformatf("t%0d_valid", i), bus.id_valid, tbl[i].v);
      chk($sformatf("t%0d_cnt", i), q_count, tbl[i].cnt);
      if (tbl[i].v) begin
        chk($sformatf("t%0d_pc", i), bus.id_pc, tbl[i].pc);
        chk($sformatf("t%0d_inst", i), bus.id_inst, mem_word(tbl[i].pc));
      end
      @(posedge clk);
      #1;
    end

    // model phase, starting from reset
    idle_inputs();
    rst = 1;
    repeat (2) model_step();
    rst = 0;

    // branch while three entries are queued and one is in flight
    fill_to3("br_fill3");
    br_e = 1; br_addr = 32'h8000_0100;
    model_step();
    br_e = 0; bus.id_ready = 1;
    repeat (6) model_step();

    // address wrap plus pointer wrap with mixed backpressure
    flush = 1; new_pc = 32'hFFFF_FFF0;
    model_step();
    flush = 0;
    repeat (10) model_step();
    for (int k = 0; k < 20; k++) begin
      bus.id_ready = ($urandom_range(0, 2) != 0);
      model_step();
    end

    // reset with three entries queued and a fetch in flight
    fill_to3("rst_fill3");
    rst = 1;
    model_step();
    rst = 0; bus.id_ready = 1;
    repeat (4) model_step();

    for (int k = 0; k < 1500; k++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      br_e  = ($urandom_range(0, 24) == 0);
      new_pc  = {$urandom()} & 32'hFFFF_FFFC;
      br_addr = {$urandom()} & 32'hFFFF_FFFC;
      bus.id_ready = ($urandom_range(0, 9) < 7);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
